// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control / multiply-divide block:
// ALU select encodings, ALUOp and funct codes, and the MDU FSM state type.
package alu_ctrl_pkg;

  // ALU select encodings
  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_SLTU = 4'b1000;
  localparam logic [3:0] SEL_NOR  = 4'b1100;

  // ALUOp from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  // R-type funct codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: latches operand magnitudes and sign
// fix-up flags on start, performs one shift-add or restoring-divide step per
// i_step, and presents sign-corrected HI/LO combinationally.
// Ports: clk, rst_n; i_start (latch operands), i_step (one iteration),
// i_is_div, i_is_signed, i_a (rs), i_b (rt); o_last_c (counter at 0),
// o_hi_c / o_lo_c (final results once iterations are complete).
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last_c,
  output logic [WIDTH-1:0] o_hi_c,
  output logic [WIDTH-1:0] o_lo_c
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    r_acc;   // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] r_b;     // multiplicand or divisor magnitude
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CW-1:0]    r_cnt;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [PW-1:0]    w_mul_next;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [PW-1:0]    w_div_next;
  logic [PW-1:0]    w_prod_neg;

  // Operand magnitudes; most-negative stays as its own unsigned magnitude
  assign w_a_neg = i_is_signed & i_a[WIDTH-1];
  assign w_b_neg = i_is_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;

  // Shift-add step: conditionally add multiplicand to upper half, shift right
  assign w_mul_sum  = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: shift next dividend bit into remainder, subtract if it fits
  assign w_rem_sh   = {r_acc[PW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_next = {(w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_rem_ge};

  assign w_prod_neg = ~r_acc + PW'(1);
  assign o_last_c   = (r_cnt == '0);

  // Operand latch and iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_is_div <= i_is_div;
      r_cnt    <= CW'(WIDTH - 1);
      if (i_is_div && (i_b == '0)) begin
        // Divide by zero: results preloaded, no iterations follow
        r_acc   <= {i_a, {WIDTH{1'b1}}};
        r_b     <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (i_is_div) begin
        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
        r_b     <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else begin
        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
        r_b     <= w_a_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= 1'b0;
      end
    end else if (i_step) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Sign fix-up of the magnitude results
  always_comb begin
    o_hi_c = r_acc[PW-1:WIDTH];
    o_lo_c = r_acc[WIDTH-1:0];
    if (r_is_div) begin
      if (r_neg_r) o_hi_c = ~r_acc[PW-1:WIDTH] + WIDTH'(1);
      if (r_neg_q) o_lo_c = ~r_acc[WIDTH-1:0] + WIDTH'(1);
    end else if (r_neg_q) begin
      o_hi_c = w_prod_neg[PW-1:WIDTH];
      o_lo_c = w_prod_neg[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control with multiply/divide unit: decodes ALUOp/funct into a 4-bit
// ALU select, sequences mult/multu/div/divu through mdu_iter, holds HI/LO and
// stalls the pipeline while an operation is in flight.
// Ports: clk, rst_n; i_alu_op, i_funct, i_valid, i_rs_val, i_rt_val;
// o_select, o_illegal, o_stall, o_mdu_result (combinational);
// o_busy, o_done, o_hi, o_lo (registered).
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_alu_op,
  input  logic [5:0]       i_funct,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  output logic [3:0]       o_select,
  output logic             o_illegal,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_mdu_result
);

  mdu_state_e       r_state, w_state_nxt;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_mdu_arith, w_mf_hi, w_mf_lo;
  logic             w_accept, w_div_zero;
  logic             w_step, w_fin;
  logic             w_last;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  // ALUOp/funct decode
  always_comb begin
    o_select    = SEL_ADD;
    o_illegal   = 1'b0;
    w_mdu_arith = 1'b0;
    w_mf_hi     = 1'b0;
    w_mf_lo     = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_select = SEL_ADD;
      ALUOP_SUB: o_select = SEL_SUB;
      ALUOP_SLT: o_select = SEL_SLT;
      default: begin
        case (i_funct)
          F_ADD, F_ADDU:                 o_select = SEL_ADD;
          F_SUB, F_SUBU:                 o_select = SEL_SUB;
          F_AND:                         o_select = SEL_AND;
          F_OR:                          o_select = SEL_OR;
          F_XOR:                         o_select = SEL_XOR;
          F_NOR:                         o_select = SEL_NOR;
          F_SLT:                         o_select = SEL_SLT;
          F_SLTU:                        o_select = SEL_SLTU;
          F_MULT, F_MULTU, F_DIV, F_DIVU: w_mdu_arith = 1'b1;
          F_MFHI:                        w_mf_hi = 1'b1;
          F_MFLO:                        w_mf_lo = 1'b1;
          default:                       o_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // funct[1] distinguishes div from mult, funct[0] the unsigned variants
  assign w_accept   = i_valid & w_mdu_arith & ~r_busy;
  assign w_div_zero = i_funct[1] & (i_rt_val == '0);

  assign o_stall      = i_valid & (w_mdu_arith | w_mf_hi | w_mf_lo) & r_busy;
  assign o_mdu_result = w_mf_hi ? r_hi : (w_mf_lo ? r_lo : '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_div_zero ? ST_FIN : ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      ST_RUN:  w_step = 1'b1;
      ST_FIN:  w_fin  = 1'b1;
      default: ;
    endcase
  end

  // Status and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_fin;
      if (w_fin) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_accept),
    .i_step      (w_step),
    .i_is_div    (i_funct[1]),
    .i_is_signed (~i_funct[0]),
    .i_a         (i_rs_val),
    .i_b         (i_rt_val),
    .o_last_c    (w_last),
    .o_hi_c      (w_res_hi),
    .o_lo_c      (w_res_lo)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu: an 8-bit and a 32-bit instance; issued
// MDU operations push expected HI/LO and completion cycle, monitors pop on done.
module tb_alu_ctrl_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        valid8, valid32;
  logic [7:0]  rs8, rt8;
  logic [31:0] rs32, rt32;

  logic [3:0]  sel8, sel32;
  logic        ill8, ill32, stall8, stall32, busy8, busy32, done8, done32;
  logic [7:0]  hi8, lo8, res8;
  logic [31:0] hi32, lo32, res32;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc_edge;
    int          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  alu_ctrl_mdu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_alu_op(alu_op), .i_funct(funct), .i_valid(valid8),
    .i_rs_val(rs8), .i_rt_val(rt8), .o_select(sel8), .o_illegal(ill8), .o_stall(stall8),
    .o_busy(busy8), .o_done(done8), .o_hi(hi8), .o_lo(lo8), .o_mdu_result(res8)
  );

  alu_ctrl_mdu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_alu_op(alu_op), .i_funct(funct), .i_valid(valid32),
    .i_rs_val(rs32), .i_rt_val(rt32), .o_select(sel32), .o_illegal(ill32), .o_stall(stall32),
    .o_busy(busy32), .o_done(done32), .o_hi(hi32), .o_lo(lo32), .o_mdu_result(res32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected result whenever a DUT signals done
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut8_unexpected_done: got done=1 expected 0 at edge %0d", edge_cnt);
      end else begin
        e = q8.pop_front();
        chk("dut8_hi", 32'(hi8), e.hi);
        chk("dut8_lo", 32'(lo8), e.lo);
        chk("dut8_done_cycle", 32'(edge_cnt - e.acc_edge + 1), 32'(e.lat));
      end
    end
    if (rst_n === 1'b1 && done32 === 1'b1) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut32_unexpected_done: got done=1 expected 0 at edge %0d", edge_cnt);
      end else begin
        e = q32.pop_front();
        chk("dut32_hi", hi32, e.hi);
        chk("dut32_lo", lo32, e.lo);
        chk("dut32_done_cycle", 32'(edge_cnt - e.acc_edge + 1), 32'(e.lat));
      end
    end
  end

  task automatic push8(input logic [7:0] eh, input logic [7:0] el, input int lat);
    exp_t e;
    e.hi = 32'(eh);
    e.lo = 32'(el);
    e.acc_edge = edge_cnt;
    e.lat = lat;
    q8.push_back(e);
  endtask

  // Issue one op to the idle 8-bit DUT; operands are scrambled after accept
  task automatic issue8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el, input int lat);
    alu_op = 2'b10; funct = f; rs8 = a; rt8 = b; valid8 = 1'b1;
    @(posedge clk); #1;
    push8(eh, el, lat);
    valid8 = 1'b0; rs8 = 8'h5A; rt8 = 8'hA5;
  endtask

  task automatic issue32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    alu_op = 2'b10; funct = f; rs32 = a; rt32 = b; valid32 = 1'b1;
    @(posedge clk); #1;
    e.hi = eh; e.lo = el; e.acc_edge = edge_cnt; e.lat = 34;
    q32.push_back(e);
    valid32 = 1'b0; rs32 = 32'h1234_5678; rt32 = 32'h9ABC_DEF0;
  endtask

  // Bounded wait for the scoreboard to drain
  task automatic wait_drain(input bit wide, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((wide ? q32.size() : q8.size()) == 0) break;
      @(posedge clk); #1;
    end
    if ((wide ? q32.size() : q8.size()) != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", wide ? "dut32" : "dut8", budget);
      if (wide) q32.delete(); else q8.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] es, input logic ei);
    alu_op = op; funct = f;
    #1;
    chk($sformatf("select_op%b_f%b", op, f), 32'(sel8), 32'(es));
    chk($sformatf("illegal_op%b_f%b", op, f), 32'(ill8), 32'(ei));
  endtask

  initial begin
    int e0;
    rst_n = 1'b0; valid8 = 1'b0; valid32 = 1'b0; alu_op = 2'b00; funct = 6'b0;
    rs8 = '0; rt8 = '0; rs32 = '0; rt32 = '0;
    #1;
    chk("reset_busy", 32'(busy8), 32'h0);
    chk("reset_done", 32'(done8), 32'h0);
    chk("reset_hi", 32'(hi8), 32'h0);
    chk("reset_lo", 32'(lo8), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode sweep
    dec(2'b00, 6'b111111, 4'b0010, 1'b0);
    dec(2'b01, 6'b111111, 4'b0110, 1'b0);
    dec(2'b11, 6'b100100, 4'b0111, 1'b0);
    dec(2'b10, 6'b100000, 4'b0010, 1'b0);
    dec(2'b10, 6'b100001, 4'b0010, 1'b0);
    dec(2'b10, 6'b100010, 4'b0110, 1'b0);
    dec(2'b10, 6'b100011, 4'b0110, 1'b0);
    dec(2'b10, 6'b100100, 4'b0000, 1'b0);
    dec(2'b10, 6'b100101, 4'b0001, 1'b0);
    dec(2'b10, 6'b100110, 4'b0011, 1'b0);
    dec(2'b10, 6'b100111, 4'b1100, 1'b0);
    dec(2'b10, 6'b101010, 4'b0111, 1'b0);
    dec(2'b10, 6'b101011, 4'b1000, 1'b0);
    dec(2'b10, 6'b011000, 4'b0010, 1'b0);
    dec(2'b10, 6'b011001, 4'b0010, 1'b0);
    dec(2'b10, 6'b011010, 4'b0010, 1'b0);
    dec(2'b10, 6'b011011, 4'b0010, 1'b0);
    dec(2'b10, 6'b010000, 4'b0010, 1'b0);
    dec(2'b10, 6'b010010, 4'b0010, 1'b0);
    dec(2'b10, 6'b111111, 4'b0010, 1'b1);
    dec(2'b10, 6'b000000, 4'b0010, 1'b1);

    // mult -3 * 5 = -15
    issue8(6'b011000, 8'hFD, 8'h05, 8'hFF, 8'hF1, 10);
    wait_drain(1'b0, 40);
    alu_op = 2'b10; funct = 6'b010000; valid8 = 1'b1; #1;
    chk("mfhi_idle_result", 32'(res8), 32'hFF);
    chk("mfhi_idle_stall", 32'(stall8), 32'h0);
    funct = 6'b010010; #1;
    chk("mflo_idle_result", 32'(res8), 32'hF1);
    funct = 6'b100000; #1;
    chk("add_mdu_result_zero", 32'(res8), 32'h0);
    valid8 = 1'b0;
    @(posedge clk); #1;

    issue8(6'b011001, 8'hFD, 8'h05, 8'h04, 8'hF1, 10);  // multu 253*5
    wait_drain(1'b0, 40);
    issue8(6'b011010, 8'hF9, 8'h02, 8'hFF, 8'hFD, 10);  // div -7/2
    wait_drain(1'b0, 40);
    issue8(6'b011011, 8'hF9, 8'h02, 8'h01, 8'h7C, 10);  // divu 249/2
    wait_drain(1'b0, 40);
    issue8(6'b011010, 8'h2A, 8'h00, 8'h2A, 8'hFF, 2);   // divide by zero
    wait_drain(1'b0, 40);
    issue8(6'b011010, 8'h80, 8'hFF, 8'h00, 8'h80, 10);  // most-negative / -1
    wait_drain(1'b0, 40);

    // Back-to-back: divu 100/7, probe mfhi/mflo and hold a mult while busy
    issue8(6'b011011, 8'h64, 8'h07, 8'h02, 8'h0E, 10);
    e0 = edge_cnt;
    repeat (2) @(posedge clk);
    #1;
    alu_op = 2'b10; funct = 6'b010010; valid8 = 1'b1; #1;
    chk("mflo_busy_stall", 32'(stall8), 32'h1);
    chk("mflo_busy_old_lo", 32'(res8), 32'h80);
    funct = 6'b010000; #1;
    chk("mfhi_busy_old_hi", 32'(res8), 32'h00);
    funct = 6'b011000; rs8 = 8'hFD; rt8 = 8'h05;
    while (edge_cnt < e0 + 9) begin
      chk("b2b_stall_while_busy", 32'(stall8), 32'h1);
      @(posedge clk); #1;
    end
    chk("b2b_stall_done_cycle", 32'(stall8), 32'h0);
    @(posedge clk); #1;
    push8(8'hFF, 8'hF1, 10);
    valid8 = 1'b0;
    wait_drain(1'b0, 40);

    // Reset during RUN
    alu_op = 2'b10; funct = 6'b011001; rs8 = 8'h33; rt8 = 8'h03; valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 32'(busy8), 32'h0);
    chk("midrun_reset_done", 32'(done8), 32'h0);
    chk("midrun_reset_hi", 32'(hi8), 32'h0);
    chk("midrun_reset_lo", 32'(lo8), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue8(6'b011011, 8'h64, 8'h07, 8'h02, 8'h0E, 10);
    wait_drain(1'b0, 40);

    // 32-bit instance
    issue32(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_drain(1'b1, 100);
    issue32(6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    wait_drain(1'b1, 100);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
